pwm_sample_scheduler: RTL and testbench

Feeds audio samples from the effect pipeline to the PWM output stage, one sample per PWM period.
- Buffers incoming samples in a small FIFO with a valid/ready handshake.
- Owns the PWM period counter and loads a new sample only at period boundaries, so the duty cycle never changes mid-period.
- Handles start-up priming, underrun and enable/disable.
- Sits between the effect chain output and the PWM comparator.

---
 rtl/pedal_pkg.sv | 16 +
 rtl/pedal_sample_fifo.sv | 71 +++++++
 rtl/pwm_sample_scheduler.sv | 118 +++++++++++
 tb/tb_pwm_sample_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pedal_pkg.sv
// Shared parameters and the scheduler state encoding
// for the pedal PWM output path.
package pedal_pkg;

  localparam int unsigned DATA_W_DEF   = 24;
  localparam int unsigned PWM_BITS_DEF = 5;
  localparam int unsigned DEPTH_DEF    = 4;
  localparam logic [DATA_W_DEF-1:0] IDLE_LEVEL_DEF = 24'h800000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/pedal_sample_fifo.sv
// Synchronous sample FIFO; head is visible on dout
// whenever the FIFO is non-empty.
module pedal_sample_fifo
  import pedal_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pwm_sample_scheduler.sv
// Buffers effect-chain samples and hands one to the PWM
// comparator per period, only at period boundaries.
module pwm_sample_scheduler
  import pedal_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [DATA_W-1:0] IDLE_LEVEL = IDLE_LEVEL_DEF,
  localparam int unsigned CW      = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DATA_W-1:0]   in_sample,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   pwm_sample,
  output logic [PWM_BITS-1:0] pwm_count,
  output logic                frame_start,
  output logic                underrun,
  input  logic                underrun_clr,
  output logic [CW-1:0]       fill_level
);

  sched_state_e        state_q, state_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                frame_q, frame_d;
  logic                underrun_q, underrun_d;
  logic                underrun_set;
  logic                pop;
  logic                fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic [CW-1:0]       fifo_count;

  pedal_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (in_sample),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    sample_d     = IDLE_LEVEL;
    pop          = 1'b0;
    underrun_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (fifo_count >= CW'(DEPTH / 2)) begin
          state_d  = RUN;
          pop      = 1'b1;
          sample_d = fifo_head;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          sample_d = sample_q;
          // period boundary: reload, or flag that nothing was there
          if (cnt_q == {PWM_BITS{1'b1}}) begin
            if (!fifo_empty) begin
              pop      = 1'b1;
              sample_d = fifo_head;
            end else begin
              underrun_set = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    frame_d    = (state_d == RUN) && (cnt_d == '0);
    underrun_d = underrun_set ? 1'b1 :
                 (underrun_clr ? 1'b0 : underrun_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sample_q   <= IDLE_LEVEL;
      frame_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sample_q   <= sample_d;
      frame_q    <= frame_d;
      underrun_q <= underrun_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign pwm_sample  = sample_q;
  assign pwm_count   = cnt_q;
  assign frame_start = frame_q;
  assign underrun    = underrun_q;
  assign fill_level  = fifo_count;

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Directed bench for pwm_sample_scheduler: priming, wrap loads,
// underrun, disable, async reset and backpressure.
module tb_pwm_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] pwm_sample;
  logic [4:0]  pwm_count;
  logic        frame_start;
  logic        underrun;
  logic        underrun_clr;
  logic [2:0]  fill_level;

  int total = 0;
  int bad   = 0;

  logic [23:0] bp_v [5];

  always #5 clk = ~clk;

  pwm_sample_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pwm_sample   (pwm_sample),
    .pwm_count    (pwm_count),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .fill_level   (fill_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cnt(input logic [4:0] target);
    int n = 0;
    while (pwm_count !== target && n < 100) begin
      step();
      n++;
    end
    chk("wait_cnt", 32'(pwm_count), 32'(target));
  endtask

  initial begin
    rst          = 1'b1;
    enable       = 1'b0;
    in_sample    = '0;
    in_valid     = 1'b0;
    underrun_clr = 1'b0;
    bp_v[0] = 24'h110000;
    bp_v[1] = 24'h120000;
    bp_v[2] = 24'h130000;
    bp_v[3] = 24'h140000;
    bp_v[4] = 24'h150000;
    step(2);
    chk("rst_sample", 32'(pwm_sample), 32'h800000);
    chk("rst_count", 32'(pwm_count), 32'd0);
    chk("rst_frame", 32'(frame_start), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // priming
    enable    = 1'b1;
    in_valid  = 1'b1;
    in_sample = 24'h100000;
    step();
    in_sample = 24'h200000;
    step();
    in_valid = 1'b0;
    chk("prime_fill2", 32'(fill_level), 32'd2);
    chk("prime_idle_sample", 32'(pwm_sample), 32'h800000);
    chk("prime_count", 32'(pwm_count), 32'd0);
    step();
    chk("run1_sample", 32'(pwm_sample), 32'h100000);
    chk("run1_frame", 32'(frame_start), 32'd1);
    chk("run1_count", 32'(pwm_count), 32'd0);
    chk("run1_fill", 32'(fill_level), 32'd1);
    step(31);
    chk("p31_count", 32'(pwm_count), 32'd31);
    chk("p31_sample", 32'(pwm_sample), 32'h100000);
    chk("p31_frame", 32'(frame_start), 32'd0);
    step();
    chk("p2_sample", 32'(pwm_sample), 32'h200000);
    chk("p2_frame", 32'(frame_start), 32'd1);
    chk("p2_fill", 32'(fill_level), 32'd0);
    chk("p2_underrun", 32'(underrun), 32'd0);

    // underrun, clear, set-wins
    wait_cnt(5'd31);
    step();
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_sample_held", 32'(pwm_sample), 32'h200000);
    chk("ur_count_wrap", 32'(pwm_count), 32'd0);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("ur_cleared", 32'(underrun), 32'd0);
    wait_cnt(5'd31);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("ur_set_wins", 32'(underrun), 32'd1);

    // push on the wrap edge with empty FIFO: no bypass
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("wb_cleared", 32'(underrun), 32'd0);
    wait_cnt(5'd31);
    in_valid  = 1'b1;
    in_sample = 24'h300000;
    step();
    in_valid = 1'b0;
    chk("wb_underrun", 32'(underrun), 32'd1);
    chk("wb_sample_held", 32'(pwm_sample), 32'h200000);
    chk("wb_fill", 32'(fill_level), 32'd1);
    wait_cnt(5'd31);
    step();
    chk("wb_loaded", 32'(pwm_sample), 32'h300000);
    chk("wb_frame", 32'(frame_start), 32'd1);
    chk("wb_fill0", 32'(fill_level), 32'd0);

    // disable mid-period
    in_valid  = 1'b1;
    in_sample = 24'h400000;
    step();
    in_sample = 24'h500000;
    step();
    in_sample = 24'h600000;
    step();
    in_valid = 1'b0;
    chk("dis_fill3", 32'(fill_level), 32'd3);
    wait_cnt(5'd13);
    enable = 1'b0;
    step();
    chk("dis_count", 32'(pwm_count), 32'd0);
    chk("dis_sample", 32'(pwm_sample), 32'h800000);
    chk("dis_frame", 32'(frame_start), 32'd0);
    chk("dis_fill", 32'(fill_level), 32'd3);
    enable = 1'b1;
    step();
    chk("reen_prime_sample", 32'(pwm_sample), 32'h800000);
    step();
    chk("reen_sample", 32'(pwm_sample), 32'h400000);
    chk("reen_frame", 32'(frame_start), 32'd1);
    chk("reen_fill", 32'(fill_level), 32'd2);

    // asynchronous reset between edges
    step(3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sample", 32'(pwm_sample), 32'h800000);
    chk("arst_count", 32'(pwm_count), 32'd0);
    chk("arst_underrun", 32'(underrun), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_fill", 32'(fill_level), 32'd0);
    chk("arst_frame", 32'(frame_start), 32'd0);
    enable = 1'b0;
    step();
    rst = 1'b0;

    // backpressure
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sample = bp_v[k];
      step();
      chk("bp_fill", 32'(fill_level), 32'(k + 1));
    end
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_sample = bp_v[4];
    step(2);
    chk("bp_held_fill", 32'(fill_level), 32'd4);
    enable = 1'b1;
    step();
    chk("bp_prime_fill", 32'(fill_level), 32'd4);
    step();
    chk("bp_run_sample", 32'(pwm_sample), 32'h110000);
    chk("bp_run_fill", 32'(fill_level), 32'd3);
    chk("bp_run_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_accept5", 32'(fill_level), 32'd4);
    for (int j = 1; j < 5; j++) begin
      wait_cnt(5'd31);
      step();
      chk("bp_order", 32'(pwm_sample), 32'(bp_v[j]));
    end
    chk("bp_no_underrun", 32'(underrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
